// File: rtl/program_mem_controller_if.sv
// program_mem_controller_if: fetcher request ports and program-memory read channels bundled together
interface program_mem_controller_if #(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CHANNELS-1:0]            mem_read_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]            mem_read_ready;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;

    modport master (
        input  consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
        output consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
    );

    modport slave (
        output consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
        input  consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
    );
endinterface

// File: rtl/program_mem_controller.sv
// program_mem_controller: round-robin arbiter relaying fetcher reads onto program-memory channels
module program_mem_controller #(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input logic                      clk,
    input logic                      reset,
    program_mem_controller_if.master bus
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {IDLE, WAITING, RELAYING} state_t;

    state_t                             state_q [NUM_CHANNELS];
    state_t                             state_d [NUM_CHANNELS];
    logic [CW-1:0]                      owner_q [NUM_CHANNELS];
    logic [CW-1:0]                      owner_d [NUM_CHANNELS];
    logic [CW-1:0]                      last_q  [NUM_CHANNELS];
    logic [CW-1:0]                      last_d  [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]           held_q, held_d;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready_q, consumer_read_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_q, consumer_read_data_d;
    logic [NUM_CHANNELS-1:0]            mem_read_valid_q, mem_read_valid_d;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address_q, mem_read_address_d;

    logic [NUM_CONSUMERS-1:0]           claimed;
    logic                               granted;
    logic [CW:0]                        cand_w;
    logic [CW-1:0]                      cand;

    assign bus.consumer_read_ready = consumer_read_ready_q;
    assign bus.consumer_read_data  = consumer_read_data_q;
    assign bus.mem_read_valid      = mem_read_valid_q;
    assign bus.mem_read_address    = mem_read_address_q;

    // Channel FSMs; channels are walked in index order so a lower channel claims a consumer first
    always_comb begin
        state_d              = state_q;
        owner_d              = owner_q;
        last_d               = last_q;
        held_d               = held_q;
        consumer_read_ready_d = consumer_read_ready_q;
        consumer_read_data_d  = consumer_read_data_q;
        mem_read_valid_d     = mem_read_valid_q;
        mem_read_address_d   = mem_read_address_q;
        claimed              = held_q;
        granted              = 1'b0;
        cand_w               = '0;
        cand                 = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_q[c])
                IDLE: begin
                    granted = 1'b0;
                    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
                        cand_w = {1'b0, last_q[c]} + (CW+1)'(k);
                        cand_w = (cand_w >= (CW+1)'(NUM_CONSUMERS)) ? cand_w - (CW+1)'(NUM_CONSUMERS) : cand_w;
                        cand   = cand_w[CW-1:0];
                        if (!granted && bus.consumer_read_valid[cand] && !claimed[cand]) begin
                            granted             = 1'b1;
                            claimed[cand]       = 1'b1;
                            held_d[cand]        = 1'b1;
                            owner_d[c]          = cand;
                            last_d[c]           = cand;
                            mem_read_valid_d[c] = 1'b1;
                            mem_read_address_d[c*ADDR_BITS +: ADDR_BITS] =
                                bus.consumer_read_address[cand*ADDR_BITS +: ADDR_BITS];
                            state_d[c]          = WAITING;
                        end
                    end
                end
                WAITING: begin
                    if (bus.mem_read_ready[c]) begin
                        mem_read_valid_d[c]                 = 1'b0;
                        consumer_read_ready_d[owner_q[c]]   = 1'b1;
                        consumer_read_data_d[owner_q[c]*DATA_BITS +: DATA_BITS] =
                            bus.mem_read_data[c*DATA_BITS +: DATA_BITS];
                        state_d[c]                          = RELAYING;
                    end
                end
                RELAYING: begin
                    if (!bus.consumer_read_valid[owner_q[c]]) begin
                        consumer_read_ready_d[owner_q[c]] = 1'b0;
                        held_d[owner_q[c]]                = 1'b0;
                        state_d[c]                        = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    // State registers; pointers reset to the last consumer so the first scan begins at consumer 0
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= IDLE;
                owner_q[c] <= '0;
                last_q[c]  <= CW'(NUM_CONSUMERS - 1);
            end
            held_q                <= '0;
            consumer_read_ready_q <= '0;
            consumer_read_data_q  <= '0;
            mem_read_valid_q      <= '0;
            mem_read_address_q    <= '0;
        end else begin
            state_q               <= state_d;
            owner_q               <= owner_d;
            last_q                <= last_d;
            held_q                <= held_d;
            consumer_read_ready_q <= consumer_read_ready_d;
            consumer_read_data_q  <= consumer_read_data_d;
            mem_read_valid_q      <= mem_read_valid_d;
            mem_read_address_q    <= mem_read_address_d;
        end
    end
endmodule

// File: tb/tb_program_mem_controller.sv
// tb_program_mem_controller: directed scoreboard bench for single- and dual-channel controllers
module tb_program_mem_controller;
    localparam int NC = 4;
    localparam int AB = 8;
    localparam int DB = 16;

    typedef struct {
        int            c;
        logic [DB-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    program_mem_controller_if #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .ADDR_BITS(AB), .DATA_BITS(DB)) a_if ();
    program_mem_controller_if #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(2), .ADDR_BITS(AB), .DATA_BITS(DB)) b_if ();

    program_mem_controller #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .ADDR_BITS(AB), .DATA_BITS(DB)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.master));
    program_mem_controller #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(2), .ADDR_BITS(AB), .DATA_BITS(DB)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.master));

    int            checks = 0;
    int            errors = 0;
    int            served_a = 0;
    int            lat_a = 0;
    int            cnt_a = 0;
    bit            resp_en = 1'b1;
    logic [NC-1:0] auto_drop = '0;
    logic [NC-1:0] rearm = '0;
    logic [NC-1:0] prev_a = '0;
    logic [AB-1:0] addr_a [NC];
    logic [DB-1:0] mem [256];
    exp_t          qa [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AB-1:0] ad);
        addr_a[i] = ad;
        a_if.consumer_read_address[i*AB +: AB] = ad;
        a_if.consumer_read_valid[i] = 1'b1;
        qa.push_back('{c: i, d: mem[ad]});
    endtask

    // one cycle: scoreboard monitor, fetcher model and memory model, all at the falling edge
    task automatic step();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            if (a_if.consumer_read_ready[i] && !prev_a[i]) begin
                served_a++;
                check("sb_nonempty", 32'(qa.size() > 0), 1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    check("sb_consumer", i, e.c);
                    check("sb_data", a_if.consumer_read_data[i*DB +: DB], e.d);
                end
                if (auto_drop[i]) a_if.consumer_read_valid[i] = 1'b0;
            end
            if (!a_if.consumer_read_ready[i] && prev_a[i] && rearm[i]) set_req(i, addr_a[i]);
        end
        prev_a = a_if.consumer_read_ready;
        if (a_if.mem_read_ready[0]) a_if.mem_read_ready[0] = 1'b0;
        else if (resp_en && a_if.mem_read_valid[0]) begin
            if (cnt_a == lat_a) begin
                a_if.mem_read_ready[0] = 1'b1;
                a_if.mem_read_data = mem[a_if.mem_read_address];
                cnt_a = 0;
            end else cnt_a++;
        end
    endtask

    task automatic do_reset();
        rearm = '0;
        auto_drop = '0;
        reset = 1'b1;
        a_if.consumer_read_valid = '0;
        a_if.mem_read_ready = '0;
        step();
        step();
        reset = 1'b0;
        qa.delete();
        prev_a = '0;
        cnt_a = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h5A3C;
        mem[8'h12] = 16'hBEEF;
        for (int i = 0; i < NC; i++) addr_a[i] = '0;
        a_if.consumer_read_valid = '0;
        a_if.consumer_read_address = '0;
        a_if.mem_read_ready = '0;
        a_if.mem_read_data = '0;
        b_if.consumer_read_valid = '0;
        b_if.consumer_read_address = '0;
        b_if.mem_read_ready = '0;
        b_if.mem_read_data = '0;

        // reset values
        step();
        step();
        check("rst_a_mvalid", a_if.mem_read_valid, 0);
        check("rst_a_maddr", a_if.mem_read_address, 0);
        check("rst_a_cready", a_if.consumer_read_ready, 0);
        check("rst_a_cdata", a_if.consumer_read_data[31:0], 0);
        check("rst_b_mvalid", b_if.mem_read_valid, 0);
        check("rst_b_cdata", b_if.consumer_read_data[63:32], 0);
        reset = 1'b0;

        // single fetch with a two-cycle memory
        lat_a = 2;
        set_req(0, 8'h12);
        step();
        check("fetch_mvalid", a_if.mem_read_valid, 1);
        check("fetch_maddr", a_if.mem_read_address, 8'h12);
        check("fetch_cready_early", a_if.consumer_read_ready, 0);
        step();
        step();
        check("fetch_mvalid_stable", a_if.mem_read_valid, 1);
        check("fetch_maddr_stable", a_if.mem_read_address, 8'h12);
        step();
        check("fetch_cready", a_if.consumer_read_ready, 4'b0001);
        check("fetch_cdata", a_if.consumer_read_data[15:0], 16'hBEEF);
        check("fetch_mvalid_clr", a_if.mem_read_valid, 0);
        step();
        step();
        check("fetch_hold", a_if.consumer_read_ready, 4'b0001);
        a_if.consumer_read_valid[0] = 1'b0;
        step();
        check("fetch_release", a_if.consumer_read_ready, 0);
        check("fetch_data_kept", a_if.consumer_read_data[15:0], 16'hBEEF);

        // contention on one zero-wait channel
        do_reset();
        lat_a = 0;
        auto_drop = '1;
        for (int i = 0; i < NC; i++) set_req(i, 8'(i * 16));
        for (int n = 0; n < 60 && qa.size() > 0; n++) step();
        check("contention_drain", qa.size(), 0);
        for (int i = 0; i < NC; i++) check("contention_slice", a_if.consumer_read_data[i*DB +: DB], mem[8'(i * 16)]);

        // round-robin fairness between two persistent fetchers
        do_reset();
        served_a = 0;
        auto_drop = 4'b0101;
        rearm = 4'b0101;
        set_req(0, 8'h40);
        set_req(2, 8'h42);
        for (int n = 0; n < 200 && served_a < 6; n++) step();
        check("rr_served", 32'(served_a >= 6), 1);
        rearm = '0;
        for (int n = 0; n < 60 && qa.size() > 0; n++) step();
        check("rr_drain", qa.size(), 0);

        // fetcher drops valid while its channel waits on memory
        do_reset();
        lat_a = 2;
        set_req(0, 8'h05);
        step();
        check("drop_mvalid", a_if.mem_read_valid, 1);
        a_if.consumer_read_valid[0] = 1'b0;
        step();
        step();
        step();
        check("drop_pulse", a_if.consumer_read_ready, 4'b0001);
        step();
        check("drop_pulse_end", a_if.consumer_read_ready, 0);
        auto_drop = 4'b0010;
        set_req(1, 8'h07);
        step();
        check("drop_back_idle", a_if.mem_read_valid, 1);
        for (int n = 0; n < 20 && qa.size() > 0; n++) step();
        check("drop_drain", qa.size(), 0);

        // reset while waiting, then a stray memory response
        do_reset();
        resp_en = 1'b0;
        set_req(3, 8'h33);
        step();
        check("rstw_mvalid", a_if.mem_read_valid, 1);
        reset = 1'b1;
        a_if.consumer_read_valid = '0;
        qa.delete();
        step();
        reset = 1'b0;
        check("rstw_mvalid_clr", a_if.mem_read_valid, 0);
        check("rstw_maddr_clr", a_if.mem_read_address, 0);
        a_if.mem_read_ready[0] = 1'b1;
        a_if.mem_read_data = 16'hDEAD;
        for (int n = 0; n < 3; n++) begin
            step();
            check("rstw_no_resp", a_if.consumer_read_ready, 0);
            check("rstw_no_data", a_if.consumer_read_data[63:48], 0);
        end

        // two channels claim two fetchers in the same cycle
        b_if.consumer_read_address = {8'h3A, 8'h00, 8'h1A, 8'h00};
        b_if.consumer_read_valid = 4'b1010;
        step();
        check("dual_mvalid", b_if.mem_read_valid, 2'b11);
        check("dual_ch0_addr", b_if.mem_read_address[7:0], 8'h1A);
        check("dual_ch1_addr", b_if.mem_read_address[15:8], 8'h3A);
        b_if.mem_read_ready = 2'b11;
        b_if.mem_read_data = {16'h3333, 16'h1111};
        step();
        b_if.mem_read_ready = 2'b00;
        check("dual_cready", b_if.consumer_read_ready, 4'b1010);
        check("dual_c1_data", b_if.consumer_read_data[31:16], 16'h1111);
        check("dual_c3_data", b_if.consumer_read_data[63:48], 16'h3333);
        b_if.consumer_read_valid = 4'b0000;
        step();
        check("dual_release", b_if.consumer_read_ready, 0);
        b_if.consumer_read_valid = 4'b0100;
        step();
        check("dual_single_claim", b_if.mem_read_valid, 2'b01);
        check("dual_single_addr", b_if.mem_read_address[7:0], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/program_mem_controller.md
PROGRAM_MEM_CONTROLLER -- requirements
Module: program_mem_controller

Interface
REQ-001: Parameter NUM_CONSUMERS, default 4, SHALL set the number of fetcher request ports.
REQ-002: Parameter NUM_CHANNELS, default 1, SHALL set the number of program-memory read channels.
REQ-003: Parameter ADDR_BITS, default 8, SHALL set the address width.
REQ-004: Parameter DATA_BITS, default 16, SHALL set the instruction width.
REQ-005: clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-006: reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-007: consumer_read_valid  input  NUM_CONSUMERS  SHALL carry one request flag per fetcher.
REQ-008: consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  SHALL carry the packed per-fetcher PC; slice i belongs to consumer i.
REQ-009: consumer_read_ready  output  NUM_CONSUMERS  SHALL carry the per-fetcher response-valid flag.
REQ-010: consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  SHALL carry the packed per-fetcher instruction.
REQ-011: mem_read_valid  output  NUM_CHANNELS  SHALL carry the per-channel memory request flag.
REQ-012: mem_read_address  output  NUM_CHANNELS*ADDR_BITS  SHALL carry the packed per-channel request address.
REQ-013: mem_read_ready  input  NUM_CHANNELS  SHALL carry the per-channel memory response flag.
REQ-014: mem_read_data  input  NUM_CHANNELS*DATA_BITS  SHALL carry the packed per-channel memory response data.

Function
REQ-015: Each channel SHALL run an independent FSM with states IDLE, WAITING and RELAYING; all outputs SHALL be registered.
REQ-016: A channel in IDLE SHALL grant one consumer that has valid=1 and is not held by any channel, scanning round-robin from (last consumer granted by that channel + 1) mod NUM_CONSUMERS.
REQ-017: When several IDLE channels arbitrate in the same cycle, lower channel index SHALL claim first, and a consumer SHALL never be granted to two channels.
REQ-018: On grant the channel SHALL, next edge, set mem_read_valid=1, load mem_read_address with the consumer's address slice, mark the consumer held, and enter WAITING.
REQ-019: In WAITING with mem_read_ready=1 the channel SHALL, next edge, clear mem_read_valid, write mem_read_data to the consumer's data slice, set that consumer_read_ready=1, and enter RELAYING.
REQ-020: In WAITING, mem_read_valid and mem_read_address SHALL hold stable until mem_read_ready is seen.
REQ-021: In RELAYING, consumer_read_ready SHALL stay 1 until consumer_read_valid for that consumer is 0.
REQ-022: When consumer_read_valid for that consumer is 0 in RELAYING, the channel SHALL, next edge, clear consumer_read_ready, release the consumer, and enter IDLE.
REQ-023: A channel SHALL not re-grant in the same cycle it releases; the earliest new grant is the following cycle.
REQ-024: mem_read_ready SHALL be ignored in IDLE and RELAYING.
REQ-025: If a consumer drops valid while its channel is WAITING, the channel SHALL complete the memory read, then pulse consumer_read_ready for exactly one cycle via RELAYING before returning to IDLE.
REQ-026: consumer_read_data slices SHALL hold their last value until overwritten by a new response for that consumer.
REQ-027: Latency SHALL be as follows: consumer valid sampled at edge N gives mem_read_valid=1 after edge N+1; mem_read_ready sampled at edge M gives consumer_read_ready=1 after edge M+1.
REQ-028: No consumer with continuously asserted valid SHALL wait more than NUM_CONSUMERS grants of the channel it is scanned by.

Reset
REQ-029: While reset=1, every FSM SHALL enter IDLE, all held flags SHALL clear, and all round-robin pointers SHALL reset so that the first scan starts at consumer 0.
REQ-030: While reset=1, mem_read_valid, mem_read_address, consumer_read_ready and consumer_read_data SHALL all be 0.
REQ-031: Reset asserted mid-transaction SHALL abandon the transaction without producing any response, and any late mem_read_ready after reset SHALL be ignored.

Verification
REQ-032: Single fetch: consumer 0 valid, addr 0x12; memory returns 0xBEEF with ready 2 cycles after request -> mem_read_valid=1 with addr 0x12 one cycle after request, consumer_read_ready[0]=1 with data 0xBEEF, held until valid drops, cleared one cycle later.
REQ-033: Contention, 1 channel: consumers 0–3 all valid with addrs 0x00/0x10/0x20/0x30, memory zero-wait -> service order 0,1,2,3, with each consumer receiving its own data slice.
REQ-034: Round-robin fairness: consumers 0 and 2 re-assert valid immediately after each release -> grants alternate 0,2,0,2 with no starvation.
REQ-035: Two channels: consumers 1 and 3 valid in the same cycle -> channel 0 takes 1 and channel 1 takes 3 in the same cycle, never both on one consumer.
REQ-036: Early drop: consumer 0 drops valid while its channel is WAITING -> consumer_read_ready[0] pulses exactly one cycle after mem_read_ready, then the channel returns to IDLE.
REQ-037: Reset while WAITING, then a stray mem_read_ready -> all outputs 0 and no consumer_read_ready asserted.
